// File: rtl/wave_framer_pkg.sv
// wave_framer_pkg: shared state encoding and framing constants for wave_framer
package wave_framer_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, SEQ, LEN, PAYLOAD, CSUM} state_t;
  localparam logic [15:0] SYNC_WORD_DFLT = 16'hA55A;
  localparam logic [15:0] TRUNC_FLAG = 16'h8000;
  localparam int SKID_DEPTH = 2;
endpackage

// File: rtl/wave_framer_skid.sv
// framer_skid: 2-entry skid buffer tracking one in-flight FIFO read, with head bypass
module framer_skid
  import wave_framer_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_rd,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [1:0]        o_occ,
  output logic              o_head_valid,
  output logic [DATA_W-1:0] o_head
);
  logic              inflight_q;
  logic [1:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [SKID_DEPTH];
  logic [DATA_W-1:0] mem_d [SKID_DEPTH];
  logic              bypass, push, pop;
  // A returning read feeds the head directly when the buffer is empty, otherwise it queues
  always_comb begin
    bypass = inflight_q & (cnt_q == 2'd0);
    o_head = bypass ? i_data : mem_q[0];
    o_head_valid = (cnt_q != 2'd0) | inflight_q;
    pop = i_pop & (cnt_q != 2'd0);
    push = inflight_q & ~(i_pop & bypass);
    cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    mem_d[0] = (push & (cnt_q == {1'b0, pop})) ? i_data : pop ? mem_q[1] : mem_q[0];
    mem_d[1] = (push & (cnt_q == 2'd1 + {1'b0, pop})) ? i_data : mem_q[1];
    o_occ = cnt_q + {1'b0, inflight_q};
  end
  // Buffer storage, fill count and the one-cycle read-latency marker
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      inflight_q <= 1'b0;
      cnt_q <= 2'd0;
      mem_q <= '{default: '0};
    end else begin
      inflight_q <= i_rd;
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end
endmodule

// File: rtl/wave_framer.sv
// wave_framer: drains the sample FIFO into sync/seq/len/payload/checksum frames on a valid/ready stream
// Optional starvation timeout enabled by defining WAVE_FRAMER_TIMEOUT_EN.
module wave_framer
  import wave_framer_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] SYNC_WORD = SYNC_WORD_DFLT
`ifdef WAVE_FRAMER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 4096
`endif
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_reading,
  input  logic [15:0]       i_recv_count,
  input  logic              i_fifo_empty,
  input  logic [DATA_W-1:0] i_fifo_data,
  output logic              o_fifo_rd,
  output logic [DATA_W-1:0] o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_start_drop
`ifdef WAVE_FRAMER_TIMEOUT_EN
  , output logic            o_timeout
`endif
);
  state_t            state_q;
  logic              reading_q, valid_q, drop_q, to_q;
  logic [15:0]       seq_q, len_q, rd_left_q, emit_left_q;
  logic [DATA_W-1:0] data_q, csum_q, head, csum_sum, trailer;
  logic [1:0]        occ;
  logic              head_valid, rise, accept, load, fifo_rd, head_take;
  framer_skid #(.DATA_W(DATA_W)) u_skid (
    .i_clk(i_clk),
    .i_rst_n(i_rst_n),
    .i_rd(fifo_rd),
    .i_data(i_fifo_data),
    .i_pop(head_take & head_valid),
    .o_occ(occ),
    .o_head_valid(head_valid),
    .o_head(head)
  );
  // Handshake, FIFO read gating and trailer value; a timed-out payload emits zeros in place of data
  always_comb begin
    rise = i_reading & ~reading_q;
    accept = valid_q & i_tx_ready;
    load = ~valid_q | i_tx_ready;
    fifo_rd = (state_q == PAYLOAD) & ~i_fifo_empty & (rd_left_q != 16'd0) & (occ < 2'(SKID_DEPTH)) & ~to_q;
    head_take = (state_q == PAYLOAD) & load & (emit_left_q != 16'd0) & (head_valid | to_q);
    csum_sum = csum_q + data_q;
    trailer = to_q ? csum_sum ^ DATA_W'(TRUNC_FLAG) : csum_sum;
  end
  assign o_fifo_rd = fifo_rd;
  assign o_tx_data = data_q;
  assign o_tx_valid = valid_q;
  assign o_busy = state_q != IDLE;
  assign o_frame_done = (state_q == CSUM) & accept;
  assign o_start_drop = drop_q;
  // Frame FSM; the output register is reloaded with the next field whenever the current one is accepted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      reading_q <= 1'b0;
      drop_q <= 1'b0;
      seq_q <= 16'd0;
      len_q <= 16'd0;
      rd_left_q <= 16'd0;
      emit_left_q <= 16'd0;
      csum_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
    end else begin
      reading_q <= i_reading;
      drop_q <= rise & (state_q != IDLE);
      if (fifo_rd) rd_left_q <= rd_left_q - 16'd1;
      if (head_take) emit_left_q <= emit_left_q - 16'd1;
      if (accept && state_q == PAYLOAD) csum_q <= csum_sum;
      case (state_q)
        IDLE: if (rise) begin
          state_q <= SYNC;
          len_q <= i_recv_count & 16'hFFFE;
          rd_left_q <= i_recv_count >> 1;
          emit_left_q <= i_recv_count >> 1;
          csum_q <= '0;
          data_q <= SYNC_WORD;
          valid_q <= 1'b1;
        end
        SYNC: if (accept) begin
          state_q <= SEQ;
          data_q <= DATA_W'(seq_q);
        end
        SEQ: if (accept) begin
          state_q <= LEN;
          data_q <= DATA_W'(len_q);
        end
        LEN: if (accept) begin
          state_q <= (emit_left_q == 16'd0) ? CSUM : PAYLOAD;
          data_q <= csum_q;
          valid_q <= emit_left_q == 16'd0;
        end
        PAYLOAD: if (head_take) begin
          data_q <= head_valid ? head : '0;
          valid_q <= 1'b1;
        end else if (accept && emit_left_q == 16'd0) begin
          state_q <= CSUM;
          data_q <= trailer;
        end else if (accept) begin
          valid_q <= 1'b0;
        end
        CSUM: if (accept) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          seq_q <= seq_q + 16'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef WAVE_FRAMER_TIMEOUT_EN
  logic [31:0] starve_q;
  assign o_timeout = o_frame_done & to_q;
  // Starvation counter: cycles with an empty FIFO and payload still unread, cleared by any read
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= 32'd0;
      to_q <= 1'b0;
    end else if (state_q == IDLE) begin
      starve_q <= 32'd0;
      to_q <= 1'b0;
    end else if (state_q == PAYLOAD) begin
      if (fifo_rd) starve_q <= 32'd0;
      else if (i_fifo_empty && rd_left_q != 16'd0 && !to_q) begin
        starve_q <= starve_q + 32'd1;
        if (starve_q == 32'(TIMEOUT_CYC - 1)) to_q <= 1'b1;
      end
    end
  end
`else
  assign to_q = 1'b0;
`endif
endmodule

// File: tb/tb_wave_framer.sv
// tb_wave_framer: directed self-checking bench for wave_framer
module tb_wave_framer;
  logic        clk = 1'b0;
  logic        rst_n, reading, fifo_empty, fifo_rd, tx_valid, tx_ready, busy, done, drop;
  logic [15:0] recv, fifo_data, tx_data;
`ifdef WAVE_FRAMER_TIMEOUT_EN
  logic        timeout;
`endif
  always #5 clk = ~clk;

`ifdef WAVE_FRAMER_TIMEOUT_EN
  wave_framer #(.TIMEOUT_CYC(16)) dut (
`else
  wave_framer dut (
`endif
    .i_clk(clk), .i_rst_n(rst_n), .i_reading(reading), .i_recv_count(recv),
    .i_fifo_empty(fifo_empty), .i_fifo_data(fifo_data), .o_fifo_rd(fifo_rd),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .o_busy(busy), .o_frame_done(done), .o_start_drop(drop)
`ifdef WAVE_FRAMER_TIMEOUT_EN
    , .o_timeout(timeout)
`endif
  );

  logic [15:0] fmem [64];
  int          wr_ptr = 0, rd_ptr = 0;
  logic        flush = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rd) begin
      fifo_data <= fmem[rd_ptr];
      rd_ptr <= rd_ptr + 1;
    end
  end

  logic [15:0] cap [256];
  int          ncap = 0, nrd = 0, ndone = 0, ndrop = 0, nto = 0, stab_err = 0;
  logic        pv = 1'b0, pr = 1'b0;
  logic [15:0] pd = 16'd0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pv && !pr && (!tx_valid || tx_data !== pd)) stab_err++;
      if (tx_valid && tx_ready) begin
        cap[ncap] = tx_data;
        ncap++;
      end
      if (fifo_rd) nrd++;
      if (done) ndone++;
      if (drop) ndrop++;
`ifdef WAVE_FRAMER_TIMEOUT_EN
      if (timeout) nto++;
`endif
    end
    pv = tx_valid & rst_n;
    pr = tx_ready;
    pd = tx_data;
  end

  int          nasrt = 0, nfail = 0, cyc = 0, base = 0, r0 = 0, dr0 = 0;
  bit          rmode = 1'b0;
  logic [15:0] expq [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nasrt++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
    tx_ready = rmode ? (cyc % 3 == 0) : 1'b1;
  endtask

  task automatic push(input logic [15:0] w);
    fmem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic start_frame(input logic [15:0] cnt);
    reading = 1'b0;
    tick;
    recv = cnt;
    reading = 1'b1;
    tick;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_sync", {15'd0, tx_valid, tx_data}, {15'd0, 1'b1, 16'hA55A});
  endtask

  task automatic wait_frame(input int budget);
    int d0;
    int n;
    d0 = ndone;
    n = 0;
    while (ndone == d0 && n < budget) begin
      tick;
      n++;
    end
    chk("frame_done_once", 32'(ndone - d0), 32'd1);
    chk("idle_after", 32'(busy), 32'd0);
  endtask

  task automatic chk_words(input string tag);
    chk({tag, "_count"}, 32'(ncap - base), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++) chk({tag, "_word"}, 32'(cap[base + i]), 32'(expq[i]));
  endtask

  initial begin
    rst_n = 1'b0;
    reading = 1'b0;
    recv = 16'd0;
    tx_ready = 1'b1;
    repeat (2) tick;
    chk("rst_ctrl", {27'd0, busy, tx_valid, fifo_rd, done, drop}, 32'd0);
    chk("rst_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    tick;

    push(16'h0102); push(16'h0304); push(16'h0506); push(16'h0708);
    base = ncap; r0 = nrd;
    start_frame(16'd8);
    reading = 1'b0;
    wait_frame(100);
    expq = {16'hA55A, 16'h0000, 16'h0008, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h1014};
    chk_words("f1");
    chk("f1_reads", 32'(nrd - r0), 32'd4);

    rmode = 1'b1;
    push(16'h0102); push(16'h0304); push(16'h0506); push(16'h0708);
    base = ncap; r0 = nrd;
    start_frame(16'd8);
    wait_frame(100);
    expq = {16'hA55A, 16'h0001, 16'h0008, 16'h0102, 16'h0304, 16'h0506, 16'h0708, 16'h1014};
    chk_words("f2_bp");
    chk("f2_reads", 32'(nrd - r0), 32'd4);
    rmode = 1'b0;

    base = ncap; r0 = nrd;
    start_frame(16'd0);
    wait_frame(50);
    expq = {16'hA55A, 16'h0002, 16'h0000, 16'h0000};
    chk_words("f3_empty");
    chk("f3_reads", 32'(nrd - r0), 32'd0);

    push(16'h1111); push(16'h2222); push(16'h3333);
    base = ncap; r0 = nrd; dr0 = ndrop;
    start_frame(16'd5);
    reading = 1'b0;
    tick;
    reading = 1'b1;
    tick;
    wait_frame(100);
    expq = {16'hA55A, 16'h0003, 16'h0004, 16'h1111, 16'h2222, 16'h3333};
    chk_words("fA_drop");
    chk("fA_reads", 32'(nrd - r0), 32'd2);
    chk("fA_drop_pulse", 32'(ndrop - dr0), 32'd1);

    push(16'h4444);
    base = ncap; r0 = nrd;
    start_frame(16'd4);
    wait_frame(100);
    expq = {16'hA55A, 16'h0004, 16'h0004, 16'h3333, 16'h4444, 16'h7777};
    chk_words("fB");
    chk("fB_reads", 32'(nrd - r0), 32'd2);

    push(16'hFFFF); push(16'h0002);
    base = ncap;
    start_frame(16'd4);
    wait_frame(100);
    expq = {16'hA55A, 16'h0005, 16'h0004, 16'hFFFF, 16'h0002, 16'h0001};
    chk_words("fC_wrap");

    push(16'h0A0A); push(16'h0B0B);
    base = ncap; r0 = ndone;
    start_frame(16'd8);
    repeat (100) tick;
`ifdef WAVE_FRAMER_TIMEOUT_EN
    chk("to_done", 32'(ndone - r0), 32'd1);
    chk("to_pulse", 32'(nto), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    expq = {16'hA55A, 16'h0006, 16'h0008, 16'h0A0A, 16'h0B0B, 16'h0000, 16'h0000, 16'h9515};
    chk_words("starve_to");
    push(16'h0C0C); push(16'h0D0D);
    flush = 1'b1;
    tick;
    flush = 1'b0;
`else
    chk("starve_wait", {30'd0, busy, tx_valid}, 32'd2);
    push(16'h0C0C); push(16'h0D0D);
    wait_frame(100);
    expq = {16'hA55A, 16'h0006, 16'h0008, 16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D, 16'h2E2E};
    chk_words("starve");
`endif

    push(16'h5555); push(16'h6666); push(16'h7777); push(16'h8888);
    start_frame(16'd8);
    repeat (4) tick;
    #2;
    reading = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctrl", {27'd0, busy, tx_valid, fifo_rd, done, drop}, 32'd0);
    chk("async_rst_data", 32'(tx_data), 32'd0);
    tick;
    rst_n = 1'b1;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    push(16'h1234);
    base = ncap;
    start_frame(16'd2);
    wait_frame(100);
    expq = {16'hA55A, 16'h0000, 16'h0002, 16'h1234, 16'h1234};
    chk_words("post_rst");

    chk("valid_stable", 32'(stab_err), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nasrt, nfail);
    $finish;
  end
endmodule
